// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO PHY sequencer: register map, bit positions,
// speed encodings and the controller state encoding.
package mdio_pkg;

    // IEEE 802.3 clause 22 register addresses
    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;

    // Bit positions inside BMCR / BMSR
    localparam int BMCR_RST  = 15;
    localparam int BMSR_LINK = 2;
    localparam int BMSR_AN   = 5;

    // Speed field encodings as reported by the vendor status register
    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // Controller states
    typedef logic [3:0] state_t;
    localparam state_t ST_BOOT      = 4'd0;
    localparam state_t ST_CFG_WR    = 4'd1;
    localparam state_t ST_CHK_RST   = 4'd2;
    localparam state_t ST_POLL_WAIT = 4'd3;
    localparam state_t ST_RD_BMSR   = 4'd4;
    localparam state_t ST_RD_SPD    = 4'd5;
    localparam state_t ST_HOST      = 4'd6;
    localparam state_t ST_ERR       = 4'd7;

    // Extract the speed field from the vendor status register value
    function automatic logic [1:0] speed_field(input logic [15:0] val);
        return val[15:14];
    endfunction

endpackage

// File: rtl/smi_txn.sv
// Single SMI transaction engine: issues a one-cycle request, holds the
// operands until the master reports completion, captures read data and
// aborts with a timeout pulse if the master never finishes.
module smi_txn #(
    parameter logic [19:0] TIMEOUT = 20'd100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        fin,
    output logic        tout,
    output logic [15:0] rdata,
    output logic [4:0]  smi_reg_addr,
    output logic [15:0] smi_write_data,
    output logic        smi_write_req,
    output logic        smi_read_req,
    input  logic [15:0] smi_read_data,
    input  logic        smi_data_valid,
    input  logic        smi_done
);

    logic [19:0] cnt;

    // Request pulse, operand hold, completion wait and timeout supervision
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= 1'b0;
            fin            <= 1'b0;
            tout           <= 1'b0;
            rdata          <= 16'd0;
            cnt            <= 20'd0;
            smi_reg_addr   <= 5'd0;
            smi_write_data <= 16'd0;
            smi_write_req  <= 1'b0;
            smi_read_req   <= 1'b0;
        end else begin
            smi_write_req <= 1'b0;
            smi_read_req  <= 1'b0;
            fin           <= 1'b0;
            tout          <= 1'b0;
            if (busy) begin
                if (smi_data_valid) begin
                    rdata <= smi_read_data;
                end
                if (smi_done) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end else if (cnt >= TIMEOUT - 20'd1) begin
                    // Counter stops here; the owner treats this as fatal
                    busy <= 1'b0;
                    tout <= 1'b1;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end else if (start) begin
                busy          <= 1'b1;
                cnt           <= 20'd0;
                smi_reg_addr  <= reg_addr;
                if (we) begin
                    smi_write_data <= wdata;
                end
                smi_write_req <= we;
                smi_read_req  <= ~we;
            end
        end
    end

endmodule

// File: rtl/mdio_phy_ctrl.sv
// PHY bring-up and status poller in front of the SMI master. Configures BMCR,
// waits for the soft reset to self-clear, then periodically reads BMSR and the
// vendor speed register. Host register accesses share the SMI master and are
// only granted between polls.
module mdio_phy_ctrl
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] BMCR_INIT    = 16'h9140,
    parameter logic [4:0]  SPEED_REG    = 5'h11,
    parameter logic [15:0] BOOT_CYCLES  = 16'd5000,
    parameter logic [23:0] POLL_CYCLES  = 24'd5_000_000,
    parameter logic [7:0]  RST_POLL_MAX = 8'd50,
    parameter logic [19:0] SMI_TIMEOUT  = 20'd100_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  smi_phy_addr,
    output logic [4:0]  smi_reg_addr,
    output logic        smi_write_req,
    output logic [15:0] smi_write_data,
    output logic        smi_read_req,
    input  logic [15:0] smi_read_data,
    input  logic        smi_data_valid,
    input  logic        smi_done,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        init_done,
    output logic        link_up,
    output logic        an_done,
    output logic [1:0]  speed,
    output logic        status_valid,
    output logic        err
);

    state_t      state;
    logic [15:0] boot_cnt;
    logic [23:0] poll_cnt;
    logic [7:0]  rst_reads;
    logic        issued;
    logic        an_pend;

    logic        txn_state;
    logic        txn_start;
    logic        txn_we;
    logic [4:0]  txn_reg;
    logic [15:0] txn_wdata;
    logic        txn_busy;
    logic        txn_fin;
    logic        txn_tout;
    logic [15:0] txn_rdata;

    assign smi_phy_addr = PHY_ADDR;

    assign txn_state = (state == ST_CFG_WR)  || (state == ST_CHK_RST) ||
                       (state == ST_RD_BMSR) || (state == ST_RD_SPD)  ||
                       (state == ST_HOST);

    // One transaction per visit to a transaction state; re-armed on completion
    assign txn_start = txn_state && !issued && !txn_busy;

    // Select the operands of the transaction owned by the current state
    always_comb begin
        txn_we    = 1'b0;
        txn_reg   = REG_BMCR;
        txn_wdata = 16'd0;
        case (state)
            ST_CFG_WR: begin
                txn_we    = 1'b1;
                txn_reg   = REG_BMCR;
                txn_wdata = BMCR_INIT;
            end
            ST_CHK_RST: txn_reg = REG_BMCR;
            ST_RD_BMSR: txn_reg = REG_BMSR;
            ST_RD_SPD:  txn_reg = SPEED_REG;
            ST_HOST: begin
                txn_we    = host_we;
                txn_reg   = host_reg;
                txn_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    smi_txn #(
        .TIMEOUT(SMI_TIMEOUT)
    ) u_txn (
        .clk            (clk),
        .rst            (rst),
        .start          (txn_start),
        .we             (txn_we),
        .reg_addr       (txn_reg),
        .wdata          (txn_wdata),
        .busy           (txn_busy),
        .fin            (txn_fin),
        .tout           (txn_tout),
        .rdata          (txn_rdata),
        .smi_reg_addr   (smi_reg_addr),
        .smi_write_data (smi_write_data),
        .smi_write_req  (smi_write_req),
        .smi_read_req   (smi_read_req),
        .smi_read_data  (smi_read_data),
        .smi_data_valid (smi_data_valid),
        .smi_done       (smi_done)
    );

    // Sequencer: boot wait, PHY init, poll scheduling, host arbitration, status
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BOOT;
            boot_cnt     <= 16'd0;
            poll_cnt     <= 24'd0;
            rst_reads    <= 8'd0;
            issued       <= 1'b0;
            an_pend      <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= 16'd0;
            init_done    <= 1'b0;
            link_up      <= 1'b0;
            an_done      <= 1'b0;
            speed        <= SPEED_10;
            status_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            host_ack     <= 1'b0;
            status_valid <= 1'b0;
            case (state)
                ST_BOOT: begin
                    // Long enough for a frame abandoned by reset to drain
                    if (boot_cnt >= BOOT_CYCLES) begin
                        state <= ST_CFG_WR;
                    end else begin
                        boot_cnt <= boot_cnt + 16'd1;
                    end
                end

                ST_POLL_WAIT: begin
                    // host_ack high means the request just served is still
                    // visible; do not mistake it for a new one
                    if (host_req && !host_ack) begin
                        state <= ST_HOST;
                    end else if (poll_cnt == 24'd0) begin
                        state <= ST_RD_BMSR;
                    end else begin
                        poll_cnt <= poll_cnt - 24'd1;
                    end
                end

                ST_ERR: ;

                ST_CFG_WR, ST_CHK_RST, ST_RD_BMSR, ST_RD_SPD, ST_HOST: begin
                    if (txn_start) begin
                        issued <= 1'b1;
                    end
                    if (txn_tout) begin
                        err    <= 1'b1;
                        issued <= 1'b0;
                        state  <= ST_ERR;
                    end else if (txn_fin) begin
                        issued <= 1'b0;
                        case (state)
                            ST_CFG_WR: state <= ST_CHK_RST;

                            ST_CHK_RST: begin
                                if (rst_reads != 8'hFF) begin
                                    rst_reads <= rst_reads + 8'd1;
                                end
                                if (!txn_rdata[BMCR_RST]) begin
                                    init_done <= 1'b1;
                                    poll_cnt  <= POLL_CYCLES;
                                    state     <= ST_POLL_WAIT;
                                end else if ({1'b0, rst_reads} + 9'd1 >= {1'b0, RST_POLL_MAX}) begin
                                    err   <= 1'b1;
                                    state <= ST_ERR;
                                end
                            end

                            ST_RD_BMSR: begin
                                if (txn_rdata[BMSR_LINK]) begin
                                    // Publish only once speed is known too
                                    an_pend <= txn_rdata[BMSR_AN];
                                    state   <= ST_RD_SPD;
                                end else begin
                                    link_up      <= 1'b0;
                                    an_done      <= txn_rdata[BMSR_AN];
                                    speed        <= SPEED_10;
                                    status_valid <= 1'b1;
                                    poll_cnt     <= POLL_CYCLES;
                                    state        <= ST_POLL_WAIT;
                                end
                            end

                            ST_RD_SPD: begin
                                link_up      <= 1'b1;
                                an_done      <= an_pend;
                                speed        <= speed_field(txn_rdata);
                                status_valid <= 1'b1;
                                poll_cnt     <= POLL_CYCLES;
                                state        <= ST_POLL_WAIT;
                            end

                            ST_HOST: begin
                                // Poll counter is left running where it was
                                host_ack <= 1'b1;
                                if (!host_we) begin
                                    host_rdata <= txn_rdata;
                                end
                                state <= ST_POLL_WAIT;
                            end

                            default: state <= ST_ERR;
                        endcase
                    end
                end

                default: begin
                    err   <= 1'b1;
                    state <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Bench for mdio_phy_ctrl: a behavioural MDIO PHY answers SMI requests and
// logs them; the stimulus process predicts transactions and status from the
// register values it programs into the PHY.
module tb_mdio_phy_ctrl;

    localparam int BOOT = 20;
    localparam int POLL = 500;
    localparam int TOUT = 300;
    localparam int RMAX = 50;

    localparam int W_SV   = 0;
    localparam int W_INIT = 1;
    localparam int W_ERR  = 2;
    localparam int W_ACK  = 3;
    localparam int W_LOG  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  smi_phy_addr;
    logic [4:0]  smi_reg_addr;
    logic        smi_write_req;
    logic [15:0] smi_write_data;
    logic        smi_read_req;
    logic [15:0] smi_read_data = 16'd0;
    logic        smi_data_valid = 1'b0;
    logic        smi_done = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [4:0]  host_reg = 5'd0;
    logic [15:0] host_wdata = 16'd0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        init_done;
    logic        link_up;
    logic        an_done;
    logic [1:0]  speed;
    logic        status_valid;
    logic        err;

    mdio_phy_ctrl #(
        .PHY_ADDR     (5'd1),
        .BMCR_INIT    (16'h9140),
        .SPEED_REG    (5'h11),
        .BOOT_CYCLES  (16'(BOOT)),
        .POLL_CYCLES  (24'(POLL)),
        .RST_POLL_MAX (8'(RMAX)),
        .SMI_TIMEOUT  (20'(TOUT))
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .smi_phy_addr   (smi_phy_addr),
        .smi_reg_addr   (smi_reg_addr),
        .smi_write_req  (smi_write_req),
        .smi_write_data (smi_write_data),
        .smi_read_req   (smi_read_req),
        .smi_read_data  (smi_read_data),
        .smi_data_valid (smi_data_valid),
        .smi_done       (smi_done),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_reg       (host_reg),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata),
        .init_done      (init_done),
        .link_up        (link_up),
        .an_done        (an_done),
        .speed          (speed),
        .status_valid   (status_valid),
        .err            (err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        longint      stamp;
    } txn_t;

    txn_t        log_q[$];
    int          log_rd = 0;
    int          reg0_reads = 0;
    int          ack_cnt = 0;
    int          sv_cnt = 0;
    bit          hang_mode = 1'b0;
    bit          stuck_mode = 1'b0;
    logic [15:0] bmsr_val = 16'h796D;
    logic [15:0] spd_val = 16'h8000;

    int n_chk = 0;
    int n_fail = 0;

    // PHY model: answers each request after a random latency, logs requests
    initial begin
        bit          m_busy;
        bit          m_rd;
        int          m_lat;
        logic [15:0] m_val;
        txn_t        ent;
        m_busy = 1'b0;
        m_rd   = 1'b0;
        m_lat  = 0;
        m_val  = 16'd0;
        forever begin
            @(negedge clk);
            smi_done       = 1'b0;
            smi_data_valid = 1'b0;
            if (host_ack) ack_cnt++;
            if (status_valid) sv_cnt++;
            if (rst) begin
                reg0_reads = 0;
                if (hang_mode) m_busy = 1'b0;
            end
            if (m_busy) begin
                if (m_lat > 0) begin
                    m_lat--;
                end else if (!hang_mode) begin
                    if (m_rd) begin
                        smi_data_valid = 1'b1;
                        smi_read_data  = m_val;
                    end
                    smi_done = 1'b1;
                    m_busy   = 1'b0;
                end
            end
            if (smi_write_req || smi_read_req) begin
                ent.we    = smi_write_req;
                ent.pa    = smi_phy_addr;
                ent.ra    = smi_reg_addr;
                ent.wd    = smi_write_data;
                ent.stamp = cyc;
                log_q.push_back(ent);
                m_rd   = smi_read_req;
                m_busy = 1'b1;
                m_lat  = $urandom_range(1, 5);
                m_val  = 16'd0;
                if (smi_read_req) begin
                    case (smi_reg_addr)
                        5'h00: begin
                            reg0_reads++;
                            m_val = (stuck_mode || reg0_reads < 3) ? 16'h9140 : 16'h1140;
                        end
                        5'h01:   m_val = bmsr_val;
                        5'h11:   m_val = spd_val;
                        5'h02:   m_val = 16'h0022;
                        default: m_val = 16'h0000;
                    endcase
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int what, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            case (what)
                W_SV:    ok = status_valid;
                W_INIT:  ok = init_done;
                W_ERR:   ok = err;
                W_ACK:   ok = host_ack;
                default: ok = (log_q.size() > log_rd);
            endcase
            if (ok) break;
        end
    endtask

    task automatic exp_txn(input string tag, input bit we, input logic [4:0] ra, input logic [15:0] wd);
        logic [63:0] got;
        if (log_rd >= log_q.size()) begin
            chk_eq({tag, "_present"}, 64'(log_q.size()), 64'(log_rd + 1));
            return;
        end
        got = {37'd0, log_q[log_rd].we, log_q[log_rd].pa, log_q[log_rd].ra,
               (log_q[log_rd].we ? log_q[log_rd].wd : 16'd0)};
        chk_eq(tag, got, {37'd0, we, 5'd1, ra, (we ? wd : 16'd0)});
        log_rd++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_init_done"}, 64'(init_done), 64'd0);
        chk_eq({tag, "_status"}, 64'({link_up, an_done, speed, status_valid}), 64'd0);
        chk_eq({tag, "_err"}, 64'(err), 64'd0);
        chk_eq({tag, "_host"}, 64'({host_ack, host_rdata}), 64'd0);
        chk_eq({tag, "_smi_req"}, 64'({smi_write_req, smi_read_req}), 64'd0);
        chk_eq({tag, "_smi_ops"}, 64'({smi_phy_addr, smi_reg_addr, smi_write_data}), 64'({5'd1, 5'd0, 16'd0}));
    endtask

    task automatic run_init(input string tag, input longint t_rel);
        bit ok;
        wait_for(W_LOG, BOOT + 60, ok);
        chk_eq({tag, "_first_req_seen"}, 64'(ok), 64'd1);
        if (ok) chk_eq({tag, "_boot_quiet"}, 64'((log_q[log_rd].stamp - t_rel) >= BOOT), 64'd1);
        wait_for(W_INIT, 1000, ok);
        chk_eq({tag, "_init_seen"}, 64'(ok), 64'd1);
        chk_eq({tag, "_reg0_reads"}, 64'(reg0_reads), 64'd3);
        chk_eq({tag, "_no_err"}, 64'(err), 64'd0);
        exp_txn({tag, "_wr_bmcr"}, 1'b1, 5'h00, 16'h9140);
        for (int i = 0; i < 3; i++) exp_txn({tag, "_rd_bmcr"}, 1'b0, 5'h00, 16'h0);
        chk_eq({tag, "_txn_count"}, 64'(log_q.size()), 64'(log_rd));
    endtask

    initial begin
        bit          ok;
        longint      t_rel;
        longint      t0;
        longint      sv_prev;
        longint      bstamp;
        int          base;
        int          acks0;
        int          n0;
        logic [15:0] bm;
        logic [15:0] sp;

        repeat (3) tick();
        chk_reset_outputs("reset");

        rst   = 1'b0;
        t_rel = cyc;
        run_init("init", t_rel);

        // Periodic polls: two directed register sets, then random ones
        base    = sv_cnt;
        sv_prev = -1;
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                bm = 16'h796D; sp = 16'h8000;
            end else if (p == 1) begin
                bm = 16'h7949; sp = 16'h8000;
            end else begin
                bm = 16'($urandom); sp = 16'($urandom);
            end
            bmsr_val = bm;
            spd_val  = sp;
            wait_for(W_SV, POLL + 200, ok);
            chk_eq("poll_seen", 64'(ok), 64'd1);
            if (!ok) break;
            chk_eq("link_up", 64'(link_up), 64'(bm[2]));
            chk_eq("an_done", 64'(an_done), 64'(bm[5]));
            chk_eq("speed", 64'(speed), 64'(bm[2] ? sp[15:14] : 2'b00));
            bstamp = (log_rd < log_q.size()) ? log_q[log_rd].stamp : 0;
            exp_txn("rd_bmsr", 1'b0, 5'h01, 16'h0);
            if (bm[2]) exp_txn("rd_spd", 1'b0, 5'h11, 16'h0);
            chk_eq("poll_txn_count", 64'(log_q.size()), 64'(log_rd));
            if (sv_prev >= 0)
                chk_eq("poll_gap", 64'((bstamp - sv_prev) >= POLL && (bstamp - sv_prev) <= POLL + 4), 64'd1);
            sv_prev = cyc;
            tick();
            chk_eq("sv_pulse", 64'(status_valid), 64'd0);
        end
        chk_eq("sv_count", 64'(sv_cnt - base), 64'd8);

        // Host write raised as the poll timer runs out: host goes first
        bmsr_val   = 16'h796D;
        spd_val    = 16'h8000;
        repeat (POLL - 3) tick();
        acks0      = ack_cnt;
        host_we    = 1'b1;
        host_reg   = 5'd4;
        host_wdata = 16'h01E1;
        host_req   = 1'b1;
        wait_for(W_ACK, 200, ok);
        chk_eq("host_wr_ack", 64'(ok), 64'd1);
        t0       = cyc;
        host_req = 1'b0;
        exp_txn("host_wr", 1'b1, 5'h04, 16'h01E1);
        wait_for(W_LOG, 20, ok);
        chk_eq("poll_after_host", 64'(ok), 64'd1);
        if (ok) chk_eq("poll_after_host_gap", 64'((log_q[log_rd].stamp - t0) <= 6), 64'd1);
        exp_txn("poll_bmsr", 1'b0, 5'h01, 16'h0);

        // Host read raised while that poll is in flight: waits for it
        host_we  = 1'b0;
        host_reg = 5'd2;
        host_req = 1'b1;
        wait_for(W_ACK, 200, ok);
        chk_eq("host_rd_ack", 64'(ok), 64'd1);
        host_req = 1'b0;
        chk_eq("host_rdata", 64'(host_rdata), 64'h0022);
        chk_eq("status_before_host", 64'({link_up, speed}), 64'({1'b1, 2'b10}));
        exp_txn("poll_spd", 1'b0, 5'h11, 16'h0);
        exp_txn("host_rd", 1'b0, 5'h02, 16'h0);
        repeat (10) tick();
        chk_eq("host_ack_count", 64'(ack_cnt - acks0), 64'd2);
        chk_eq("host_rdata_held", 64'(host_rdata), 64'h0022);

        // Reset while the speed register read is outstanding
        ok = 1'b0;
        for (int i = 0; i < POLL + 100; i++) begin
            tick();
            if (log_q.size() > log_rd && log_q[log_q.size() - 1].ra == 5'h11) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("rd_spd_seen", 64'(ok), 64'd1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst    = 1'b0;
        t_rel  = cyc;
        log_rd = log_q.size();
        run_init("reinit", t_rel);

        // Fault: soft reset never clears
        stuck_mode = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        log_rd = log_q.size();
        wait_for(W_ERR, 3000, ok);
        chk_eq("stuck_err", 64'(ok), 64'd1);
        chk_eq("stuck_reads", 64'(reg0_reads), 64'(RMAX));
        chk_eq("stuck_no_init", 64'(init_done), 64'd0);
        n0       = log_q.size();
        acks0    = ack_cnt;
        host_we  = 1'b0;
        host_reg = 5'd3;
        host_req = 1'b1;
        repeat (100) tick();
        chk_eq("stuck_no_ack", 64'(ack_cnt), 64'(acks0));
        chk_eq("stuck_smi_idle", 64'(log_q.size()), 64'(n0));
        chk_eq("stuck_err_sticky", 64'(err), 64'd1);
        host_req = 1'b0;

        // Fault: SMI master never completes
        stuck_mode = 1'b0;
        hang_mode  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        log_rd = log_q.size();
        wait_for(W_LOG, BOOT + 60, ok);
        chk_eq("hang_req_seen", 64'(ok), 64'd1);
        t0 = ok ? log_q[log_rd].stamp : cyc;
        wait_for(W_ERR, TOUT + 100, ok);
        chk_eq("hang_err", 64'(ok), 64'd1);
        chk_eq("hang_err_time", 64'((cyc - t0) >= TOUT && (cyc - t0) <= TOUT + 4), 64'd1);
        acks0    = ack_cnt;
        host_req = 1'b1;
        repeat (100) tick();
        chk_eq("hang_no_ack", 64'(ack_cnt), 64'(acks0));
        chk_eq("hang_smi_idle", 64'(log_q.size()), 64'(log_rd + 1));
        chk_eq("hang_err_sticky", 64'(err), 64'd1);
        host_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
